lane_rx_buffer: RTL and testbench
=================================

# lane_rx_buffer

Parametrised multi-lane serial receiver for the PCIe-style link datapath. Each lane deserialises a 1-bit stream MSB-first, locks word alignment on the comma symbol (BC), declares the lane active after a run of consecutive commas, and buffers non-comma data words in a per-lane FIFO. Read-side logic drains the FIFOs through a per-lane pop handshake. It generalises the fixed two-lane, 8-bit receive device to N lanes with configurable width, comma, lock threshold, depth and watermarks, plus overflow reporting.

## Interface

- LANES, 2, number of independent serial lanes
- WIDTH, 8, word width in bits
- COMMA, 8'hBC, alignment/idle symbol (WIDTH bits)
- ACTIVE_COUNT, 4, consecutive aligned commas required to go active (≥1)
- DEPTH, 8, FIFO entries per lane (power of 2, ≥4)
- AF_LEVEL, 6, almost_full threshold (count ≥ AF_LEVEL)
- AE_LEVEL, 2, almost_empty threshold (count ≤ AE_LEVEL)

- clk  in  1  single clock; all lanes and FIFOs run on it
- reset  in  1  asynchronous, active-low; clears all state
- in  in  LANES  serial bit per lane, sampled on rising clk
- read  in  LANES  per-lane pop request
- out  out  LANES*WIDTH  popped word; lane i in bits [i*WIDTH +: WIDTH]
- valid_out  out  LANES  lane i's out updated this cycle
- active  out  LANES  lane locked and forwarding data
- empty, full  out  LANES each  per-lane FIFO status
- almost_empty, almost_full  out  LANES each  per-lane watermarks
- overflow  out  LANES  sticky: a word was dropped because FIFO full

## Operation

- Per lane: shift register sh; candidate word w = {sh[WIDTH-2:0], in}; sh <= w every cycle.
- Lane FSM states: HUNT, ALIGN, ACTIVE. Bit counter bc (0..WIDTH-1), comma counter cc.
- HUNT: every cycle, if w == COMMA → ALIGN, bc <= 0, cc <= 1 (bit-granular search, any phase).
- ALIGN: bc increments each cycle; at bc == WIDTH-1 (word boundary) bc <= 0 and:
  - w == COMMA: cc <= cc+1; if cc+1 == ACTIVE_COUNT → ACTIVE.
  - w != COMMA: → HUNT, cc <= 0.
  - ACTIVE_COUNT == 1: HUNT goes directly to ACTIVE on first comma.
- ACTIVE: at each word boundary, w == COMMA is discarded (idle); any other w is written to the lane FIFO. ACTIVE is left only by reset.
- active[i] = (state == ACTIVE), registered.
- FIFO: DEPTH entries, wr/rd pointers log2(DEPTH) bits wrapping naturally, occupancy count log2(DEPTH)+1 bits.
- Write while full without pop: word dropped, overflow[i] <= 1 (sticky until reset).
- Pop (read[i] && !empty[i]): out lane i <= head word, valid_out[i] <= 1 for that cycle; otherwise valid_out[i] <= 0, out holds last value.
- read on empty: ignored, no underflow, no status change.
- Simultaneous write and pop: full → both succeed, count unchanged; empty → write accepted, pop ignored (no bypass).
- Status derived from count: empty (==0), full (==DEPTH), almost_full (≥AF_LEVEL), almost_empty (≤AE_LEVEL); all registered with count.
- Lanes fully independent; no inter-lane deskew.

## Timing

- Reset values: out 0, valid_out 0, active 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0; FSM HUNT, sh/bc/cc/pointers/count 0.
- Reset asserted mid-operation: all above values immediately (async); buffered words lost.
- First comma: last comma bit sampled at edge E0 → ALIGN after E0.
- Lock: ACTIVE_COUNT-th comma's last bit at edge Ek → active high after Ek. Word after it: first bit sampled at Ek+1.
- Data latency: last bit of a data word at edge E → count/empty update after E; read high in the following cycle → out/valid_out after E+1. Minimum bit-in to out: 1 clk after word completion.
- Sustained throughput: one word per WIDTH clocks per lane; read side may pop one word per clk.

## Test plan

- Reset: hold reset low 6 clks with toggling in/read → all outputs at reset values; release → unchanged until commas arrive.
- Sub-threshold lock: lane 0 sends 3× BC then FF → active[0] stays 0, empty[0] stays 1; then BC→lock restarts only after a new comma.
- Lock and data: both lanes send 5× BC, then FF, DD, EE, CC → active high after 4th BC; 5th BC not stored; pops return FF, DD, EE, CC in order, valid_out one cycle each.
- Misaligned start: 3 junk bits, then BC BC BC BC, AA → lock at bit offset 3, pop returns AA.
- Fill/overflow: locked lane, 9 data words (BB,99,AA,88,…) without reads → almost_full after 6th, full after 8th, 9th dropped, overflow=1; 8 pops return first 8 words, empty=1, overflow still 1.
- Simultaneous/edge: pop on the cycle a word completes while full → count stays 8, no overflow; read on empty → valid_out 0; reset mid-stream → active 0, empty 1 immediately.

Source files
------------

// File: rtl/lane_rx_buffer.sv
// Multi-lane serial receiver: per-lane comma alignment and lock, with data words
// buffered in a per-lane FIFO that the read side drains through a pop handshake.
module lane_rx_buffer #(
  parameter int               LANES        = 2,
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] COMMA        = WIDTH'(8'hBC),
  parameter int               ACTIVE_COUNT = 4,
  parameter int               DEPTH        = 8,
  parameter int               AF_LEVEL     = 6,
  parameter int               AE_LEVEL     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in,
  input  logic [LANES-1:0]       read,
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES-1:0]       active,
  output logic [LANES-1:0]       empty,
  output logic [LANES-1:0]       full,
  output logic [LANES-1:0]       almost_empty,
  output logic [LANES-1:0]       almost_full,
  output logic [LANES-1:0]       overflow
);

  localparam int BC_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CC_W  = $clog2(ACTIVE_COUNT + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(WIDTH - 1);
  localparam logic [CC_W-1:0]  CC_TGT  = CC_W'(ACTIVE_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE  = CNT_W'(AE_LEVEL);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] w_word;
    state_t           r_state;
    logic [BC_W-1:0]  r_bc;
    logic [CC_W-1:0]  r_cc;
    logic             r_active;
    logic             w_comma, w_bound, w_wr, w_pop, w_acc;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp, r_rp;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_out;
    logic             r_vld, r_empty, r_full, r_ae, r_af, r_ovf;

    assign w_word    = {r_sh, in[g]};
    assign w_comma   = (w_word == COMMA);
    assign w_bound   = (r_bc == BC_LAST);
    assign w_wr      = (r_state == LOCKED) && w_bound && !w_comma;
    assign w_pop     = read[g] && !r_empty;
    // A full FIFO still accepts a write when the same edge pops a word.
    assign w_acc     = w_wr && (!r_full || w_pop);
    assign w_cnt_nxt = r_cnt + CNT_W'(w_acc) - CNT_W'(w_pop);

    // Alignment: bit-granular hunt, then word-granular comma counting.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sh     <= '0;
        r_state  <= HUNT;
        r_bc     <= '0;
        r_cc     <= '0;
        r_active <= 1'b0;
      end else begin
        r_sh <= w_word[WIDTH-2:0];
        case (r_state)
          HUNT: begin
            if (w_comma) begin
              r_bc <= '0;
              if (ACTIVE_COUNT == 1) begin
                r_state  <= LOCKED;
                r_active <= 1'b1;
              end else begin
                r_state <= ALIGN;
                r_cc    <= CC_W'(1);
              end
            end
          end
          ALIGN: begin
            if (w_bound) begin
              r_bc <= '0;
              if (w_comma) begin
                r_cc <= r_cc + CC_W'(1);
                if ((r_cc + CC_W'(1)) == CC_TGT) begin
                  r_state  <= LOCKED;
                  r_active <= 1'b1;
                end
              end else begin
                r_state <= HUNT;
                r_cc    <= '0;
              end
            end else begin
              r_bc <= r_bc + BC_W'(1);
            end
          end
          LOCKED:  r_bc <= w_bound ? '0 : r_bc + BC_W'(1);
          default: r_state <= HUNT;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_acc) r_mem[r_wp] <= w_word;
    end

    // FIFO control and registered status, all derived from the next count.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_cnt   <= '0;
        r_out   <= '0;
        r_vld   <= 1'b0;
        r_empty <= 1'b1;
        r_full  <= 1'b0;
        r_ae    <= 1'b1;
        r_af    <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_acc) r_wp <= r_wp + PTR_W'(1);
        if (w_pop) begin
          r_rp  <= r_rp + PTR_W'(1);
          r_out <= r_mem[r_rp];
        end
        if (w_wr && !w_acc) r_ovf <= 1'b1;
        r_vld   <= w_pop;
        r_cnt   <= w_cnt_nxt;
        r_empty <= (w_cnt_nxt == '0);
        r_full  <= (w_cnt_nxt == CNT_MAX);
        r_af    <= (w_cnt_nxt >= CNT_AF);
        r_ae    <= (w_cnt_nxt <= CNT_AE);
      end
    end

    assign out[g*WIDTH +: WIDTH] = r_out;
    assign valid_out[g]          = r_vld;
    assign active[g]             = r_active;
    assign empty[g]              = r_empty;
    assign full[g]               = r_full;
    assign almost_empty[g]       = r_ae;
    assign almost_full[g]        = r_af;
    assign overflow[g]           = r_ovf;
  end

endmodule

// File: tb/tb_lane_rx_buffer.sv
// Bench for lane_rx_buffer: word-level vector table over two lanes plus
// hand-written reset, mid-stream reset and misaligned-lock sequences.
module tb_lane_rx_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in, read;
  logic [15:0] out;
  logic [1:0]  valid_out, active, empty, full, almost_empty, almost_full, overflow;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lane_rx_buffer #(
    .LANES(2), .WIDTH(8), .COMMA(8'hBC), .ACTIVE_COUNT(4),
    .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .read(read), .out(out),
    .valid_out(valid_out), .active(active), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow)
  );

  typedef struct {
    logic [7:0] tx0, tx1;
    logic [1:0] rd1, rd8, ev;
    logic [7:0] eo0, eo1;
    logic [1:0] act, emp, ful, af, ae, ovf;
  } vec_t;

  vec_t tbl [35];

  function automatic vec_t mk(input logic [7:0] t0, input logic [7:0] t1,
                              input logic [1:0] r1, input logic [1:0] r8, input logic [1:0] ev,
                              input logic [7:0] o0, input logic [7:0] o1,
                              input logic [1:0] ac, input logic [1:0] em, input logic [1:0] fu,
                              input logic [1:0] af, input logic [1:0] ae, input logic [1:0] ov);
    vec_t v;
    v.tx0 = t0; v.tx1 = t1; v.rd1 = r1; v.rd8 = r8; v.ev = ev; v.eo0 = o0; v.eo1 = o1;
    v.act = ac; v.emp = em; v.ful = fu; v.af = af; v.ae = ae; v.ovf = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic step(input logic [1:0] bits, input logic [1:0] rd);
    in   = bits;
    read = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input logic [1:0] rd_first);
    for (int b = 0; b < 8; b++)
      step({w1[7-b], w0[7-b]}, (b == 0) ? rd_first : 2'b00);
  endtask

  task automatic chk_status(input string tag, input logic [1:0] ac, input logic [1:0] em,
                            input logic [1:0] fu, input logic [1:0] af, input logic [1:0] ae,
                            input logic [1:0] ov);
    chk({tag, " active"}, 32'(active), 32'(ac));
    chk({tag, " empty"}, 32'(empty), 32'(em));
    chk({tag, " full"}, 32'(full), 32'(fu));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, " overflow"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    // W1-W4: lane 0 sub-threshold (3 commas then FF); W5-W9: both lanes 5 commas.
    tbl[0]  = mk(8'hBC, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[1]  = mk(8'hBC, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[2]  = mk(8'hBC, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[3]  = mk(8'hFF, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[4]  = mk(8'hBC, 8'hBC, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[5]  = mk(8'hBC, 8'hBC, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[6]  = mk(8'hBC, 8'hBC, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[7]  = mk(8'hBC, 8'hBC, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[8]  = mk(8'hBC, 8'hBC, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    // W10-W13: data FF DD EE CC; W14-W17: pop them; W18: read on empty.
    tbl[9]  = mk(8'hFF, 8'hFF, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[10] = mk(8'hDD, 8'hDD, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[11] = mk(8'hEE, 8'hEE, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[12] = mk(8'hCC, 8'hCC, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[13] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'hFF, 8'hFF, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[14] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'hDD, 8'hDD, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[15] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'hEE, 8'hEE, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[16] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'hCC, 8'hCC, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[17] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    // W19-W26: fill both lanes to 8.
    tbl[18] = mk(8'hBB, 8'hBB, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[19] = mk(8'h99, 8'h99, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    tbl[20] = mk(8'hAA, 8'hAA, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[21] = mk(8'h88, 8'h88, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[22] = mk(8'h77, 8'h77, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[23] = mk(8'h66, 8'h66, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl[24] = mk(8'h55, 8'h55, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl[25] = mk(8'h44, 8'h44, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    // W27: lane 0 drops 33 (overflow); lane 1 pops on the completing edge and keeps 33.
    tbl[26] = mk(8'h33, 8'h33, 2'b00, 2'b10, 2'b10, 8'h00, 8'hBB, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01);
    // W28-W35: drain both lanes.
    tbl[27] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'hBB, 8'h99, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01);
    tbl[28] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'h99, 8'hAA, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01);
    tbl[29] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'hAA, 8'h88, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    tbl[30] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'h88, 8'h77, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    tbl[31] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'h77, 8'h66, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    tbl[32] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'h66, 8'h55, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01);
    tbl[33] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'h55, 8'h44, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01);
    tbl[34] = mk(8'hBC, 8'hBC, 2'b11, 2'b00, 2'b11, 8'h44, 8'h33, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01);

    // Reset held low with toggling inputs.
    reset = 1'b0;
    in    = 2'b00;
    read  = 2'b00;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] t;
      t = 2'(i);
      step(t, ~t);
    end
    chk("rst out", 32'(out), 32'h0);
    chk("rst valid_out", 32'(valid_out), 32'h0);
    chk_status("rst", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(2'b00, 2'b11);
    chk("idle valid_out", 32'(valid_out), 32'h0);
    chk_status("idle", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);

    for (int i = 0; i < 35; i++) begin
      vec_t v;
      string tag;
      v   = tbl[i];
      tag = $sformatf("w%0d", i + 1);
      for (int b = 0; b < 8; b++) begin
        logic [1:0] rd;
        rd = (b == 0) ? v.rd1 : ((b == 7) ? v.rd8 : 2'b00);
        step({v.tx1[7-b], v.tx0[7-b]}, rd);
        if (b == 0 || b == 7) begin
          logic [1:0] ev;
          ev = (rd != 2'b00) ? v.ev : 2'b00;
          chk($sformatf("%s valid_out b%0d", tag, b), 32'(valid_out), 32'(ev));
          if (ev[0]) chk({tag, " out0"}, 32'(out[7:0]), 32'(v.eo0));
          if (ev[1]) chk({tag, " out1"}, 32'(out[15:8]), 32'(v.eo1));
        end
        if (b == 1) chk({tag, " valid_out pulse"}, 32'(valid_out), 32'h0);
      end
      chk_status(tag, v.act, v.emp, v.ful, v.af, v.ae, v.ovf);
    end

    // Reset asserted between edges while holding a buffered word.
    send_word(8'h5A, 8'hBC, 2'b00);
    chk("pre-reset empty", 32'(empty), 32'h2);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00);
    #2 reset = 1'b0;
    #1;
    chk("midrst out", 32'(out), 32'h0);
    chk("midrst valid_out", 32'(valid_out), 32'h0);
    chk_status("midrst", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    reset = 1'b1;

    // Lane 0 locks at a 3-bit offset after junk bits 1,1,0.
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);
    for (int i = 0; i < 3; i++) send_word(8'hBC, 8'h00, 2'b00);
    chk("mis 3 commas active", 32'(active), 32'h0);
    send_word(8'hBC, 8'h00, 2'b00);
    chk("mis lock active", 32'(active), 32'h1);
    send_word(8'hAA, 8'h00, 2'b00);
    chk("mis data empty", 32'(empty), 32'h2);
    step(2'b00, 2'b01);
    chk("mis pop valid_out", 32'(valid_out), 32'h1);
    chk("mis pop out0", 32'(out[7:0]), 32'hAA);
    chk("mis post empty", 32'(empty), 32'h3);
    step(2'b00, 2'b00);
    chk("mis valid_out low", 32'(valid_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
